alu_multicycle: RTL and testbench

//   Parametrised successor to the single-cycle datapath ALU. Adds registered outputs, a

---
 rtl/alu_multicycle.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with registered results and a valid/ready input.
// Single-cycle ops (logic, add/sub, compares, shifts) return a result one cycle
// after the accept edge. MULT/MULTU (shift-add) and DIV/DIVU (restoring divide)
// iterate one bit per cycle on operand magnitudes and fix the signs at the end.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             abort,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_SLTU  = 4'b1110;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Iteration datapath: mcand is multiplicand (MUL) or divisor (DIV);
  // acc_hi/acc_lo hold the running product, or remainder/quotient.
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg_lo;
  logic             neg_hi;

  // Two's-complement negate under a condition, used for magnitudes and sign fixup.
  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic en, input logic [2*WIDTH-1:0] v);
    return en ? (~v + 1'b1) : v;
  endfunction

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             is_signed;
  logic             b_is_zero;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (operation == OP_MULT) | (operation == OP_MULTU);
  assign is_div    = (operation == OP_DIV)  | (operation == OP_DIVU);
  assign is_signed = (operation == OP_MULT) | (operation == OP_DIV);
  assign b_is_zero = (data_b == '0);
  assign sign_a    = is_signed & data_a[WIDTH-1];
  assign sign_b    = is_signed & data_b[WIDTH-1];
  assign mag_a     = neg_if(sign_a, data_a);
  assign mag_b     = neg_if(sign_b, data_b);

  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] diff_ab;
  logic [CNT_W-2:0] shamt;

  assign sum_ab  = data_a + data_b;
  assign diff_ab = data_a - data_b;
  assign shamt   = data_b[CNT_W-2:0];

  // Single-cycle result and ADD/SUB signed overflow.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (operation)
      OP_AND: sc_res = data_a & data_b;
      OP_OR:  sc_res = data_a | data_b;
      OP_XOR: sc_res = data_a ^ data_b;
      OP_NOR: sc_res = ~(data_a | data_b);
      OP_ADD: begin
        sc_res = sum_ab;
        sc_ovf = (data_a[WIDTH-1] == data_b[WIDTH-1]) && (sum_ab[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff_ab;
        sc_ovf = (data_a[WIDTH-1] != data_b[WIDTH-1]) && (diff_ab[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (data_a < data_b)};
      OP_SLL:  sc_res = data_a << shamt;
      OP_SRL:  sc_res = data_a >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(data_a) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // One iteration step. For DIV the remainder never exceeds the divisor, so
  // bit WIDTH of the trial subtraction is set exactly when it borrows.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_sub;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_sub   = div_shift - {1'b0, mcand};

  // Select the next accumulator value for the active iterative operation.
  always_comb begin
    it_hi = mul_sum[WIDTH:1];
    it_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (state == S_DIV) begin
      it_hi = div_sub[WIDTH] ? div_shift[WIDTH-1:0] : div_sub[WIDTH-1:0];
      it_lo = {acc_lo[WIDTH-2:0], ~div_sub[WIDTH]};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;

  assign prod_fix = neg2_if(neg_lo, {it_hi, it_lo});
  assign fin_lo   = (state == S_MUL) ? prod_fix[WIDTH-1:0]       : neg_if(neg_lo, it_lo);
  assign fin_hi   = (state == S_MUL) ? prod_fix[2*WIDTH-1:WIDTH] : neg_if(neg_hi, it_hi);

  // Iteration registers: loaded on accept, stepped every cycle while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand  <= is_div ? mag_b : mag_a;
      acc_lo <= is_div ? mag_a : mag_b;
      acc_hi <= '0;
      neg_lo <= sign_a ^ sign_b;
      neg_hi <= sign_a;
    end else if (state != S_IDLE) begin
      acc_hi <= it_hi;
      acc_lo <= it_lo;
    end
  end

  // Control FSM with registered result and flag outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (is_mul) begin
              state <= S_MUL;
            end else if (is_div && !b_is_zero) begin
              state <= S_DIV;
            end else if (is_div) begin
              out_valid <= 1'b1;
              result_lo <= '1;
              result_hi <= data_a;
              zero      <= 1'b0;
              overflow  <= 1'b0;
              div_zero  <= 1'b1;
            end else begin
              out_valid <= 1'b1;
              result_lo <= sc_res;
              result_hi <= '0;
              zero      <= (sc_res == '0);
              overflow  <= sc_ovf;
              div_zero  <= 1'b0;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == LAST_ITER) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b1;
            result_lo <= fin_lo;
            result_hi <= fin_hi;
            zero      <= (fin_lo == '0);
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors for alu_multicycle (WIDTH=32) plus
// hand-written sequences for back-to-back issue, abort and mid-operation reset.
module tb_alu_multicycle;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        abort;
  logic        out_valid;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;
  logic        div_zero;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .data_a    (data_a),
    .data_b    (data_b),
    .abort     (abort),
    .out_valid (out_valid),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .zero      (zero),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input logic z, input logic ov, input logic dz, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
    v.z = z; v.ov = ov; v.dz = dz; v.lat = lat;
    vq.push_back(v);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    operation = op;
    data_a    = a;
    data_b    = b;
    in_valid  = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_lo"}, result_lo, 32'h0);
    check({tag, "_hi"}, result_hi, 32'h0);
    check({tag, "_zero"}, {31'b0, zero}, 32'd1);
    check({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
    check({tag, "_div_zero"}, {31'b0, div_zero}, 32'd0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    int low_cnt;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    operation = 4'h0;
    data_a    = 32'h0;
    data_b    = 32'h0;
    abort     = 1'b0;

    // op, a, b, lo, hi, zero, overflow, div_zero, latency
    add_vec(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1);
    add_vec(4'b0010, 32'h00000005, 32'h00000003, 32'h00000008, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    add_vec(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1);
    add_vec(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    add_vec(4'b0100, 32'h00000001, 32'h00000021, 32'h00000002, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b1000, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    add_vec(4'b1001, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33);
    add_vec(4'b1010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0, 33);
    add_vec(4'b1001, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 33);
    add_vec(4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 33);
    add_vec(4'b1011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33);
    add_vec(4'b1011, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1'b0, 33);
    add_vec(4'b1101, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 1'b0, 1'b0, 1'b1, 1);
    add_vec(4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 33);
    add_vec(4'b1101, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, 1'b0, 33);

    // Reset state, both while held and after release
    repeat (2) tick();
    check_reset_vals("rst_held");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_reset_vals("rst_rel");

    // Table-driven vectors
    foreach (vq[i]) begin
      issue(vq[i].op, vq[i].a, vq[i].b);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
        tick();
        lat++;
      end
      check($sformatf("v%0d_latency", i), lat, vq[i].lat);
      check($sformatf("v%0d_lo", i), result_lo, vq[i].lo);
      check($sformatf("v%0d_hi", i), result_hi, vq[i].hi);
      check($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vq[i].z});
      check($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vq[i].ov});
      check($sformatf("v%0d_div_zero", i), {31'b0, div_zero}, {31'b0, vq[i].dz});
      tick();
    end

    // Back-to-back single-cycle ops, then hold of the last result
    issue(4'b0110, 32'd5, 32'd5);
    tick();
    check("b2b_sub_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_sub_lo", result_lo, 32'h0);
    check("b2b_sub_zero", {31'b0, zero}, 32'd1);
    issue(4'b1110, 32'd1, 32'hFFFFFFFF);
    tick();
    check("b2b_sltu_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_sltu_lo", result_lo, 32'h1);
    issue(4'b1000, 32'h80000000, 32'd4);
    tick();
    check("b2b_sra_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_sra_lo", result_lo, 32'hF8000000);
    in_valid = 1'b0;
    tick();
    check("hold_valid", {31'b0, out_valid}, 32'd0);
    check("hold_lo", result_lo, 32'hF8000000);

    // MULT: in_ready low for exactly 32 cycles, released together with out_valid
    issue(4'b1001, 32'hFFFFFFFD, 32'd7);
    tick();
    in_valid = 1'b0;
    low_cnt = 0;
    while (!in_ready && low_cnt < 40) begin
      low_cnt++;
      tick();
    end
    check("mul_ready_low_cycles", low_cnt, 32);
    check("mul_valid_with_ready", {31'b0, out_valid}, 32'd1);
    check("mul_lo", result_lo, 32'hFFFFFFEB);
    tick();

    // Abort in-flight DIVU: no result, prior result retained
    issue(4'b0010, 32'd2, 32'd2);
    tick();
    in_valid = 1'b0;
    check("pre_abort_lo", result_lo, 32'd4);
    issue(4'b1101, 32'd100, 32'd7);
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      if (out_valid) seen++;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", {31'b0, in_ready}, 32'd1);
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_valid", seen, 0);
    check("abort_lo_kept", result_lo, 32'd4);
    check("abort_hi_kept", result_hi, 32'd0);

    // abort together with in_valid in IDLE still accepts
    abort = 1'b1;
    issue(4'b0010, 32'd1, 32'd1);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_idle_valid", {31'b0, out_valid}, 32'd1);
    check("abort_idle_lo", result_lo, 32'd2);
    tick();

    // Reset mid-DIVU: immediate return to reset values, partial result lost
    issue(4'b1101, 32'd100, 32'd7);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    check("midrst_lo", result_lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
